bitline_write_sequencer: RTL and testbench

//   Next-generation SRAM column write driver. It accepts one masked word-write

---
 rtl/bitline_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_bitline_write_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitline_write_sequencer.sv
// bitline_write_sequencer: sequences one masked SRAM word write through the
// precharge, drive and recovery phases, with registered bitline and wordline outputs.
`default_nettype none

module bitline_write_sequencer #(
  parameter int WORD_SIZE    = 4,
  parameter int NUM_WORDS    = 16,
  parameter int PRE_CYCLES   = 1,
  parameter int DRIVE_CYCLES = 2,
  parameter int REC_CYCLES   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(NUM_WORDS)-1:0]   req_word,
  input  logic [WORD_SIZE-1:0]           req_data,
  input  logic [WORD_SIZE-1:0]           req_mask,
  output logic                           precharge_en,
  output logic                           wl_en,
  output logic [WORD_SIZE*NUM_WORDS-1:0] bl,
  output logic [WORD_SIZE*NUM_WORDS-1:0] blb,
  output logic [WORD_SIZE*NUM_WORDS-1:0] bl_drv_en,
  output logic                           busy,
  output logic                           done
);

  localparam int NUM_COLS = WORD_SIZE * NUM_WORDS;
  localparam int WW       = $clog2(NUM_WORDS);
  localparam int MAX_CYC  = (PRE_CYCLES > DRIVE_CYCLES)
                            ? ((PRE_CYCLES > REC_CYCLES) ? PRE_CYCLES : REC_CYCLES)
                            : ((DRIVE_CYCLES > REC_CYCLES) ? DRIVE_CYCLES : REC_CYCLES);
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(REC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRECHARGE = 2'd1,
    S_DRIVE     = 2'd2,
    S_RECOVER   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]        word_q;
  logic [WORD_SIZE-1:0] data_q, mask_q;
  logic                 pre_q, pre_d, wl_q, wl_d, done_q, done_d;
  logic [NUM_COLS-1:0]  bl_q, bl_d, blb_q, blb_d, drv_q, drv_d;
  logic [NUM_COLS-1:0]  drv_pat, bl_pat, blb_pat;
  logic                 accept;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Out-of-range word indices match no word, so nothing is driven for them.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < WORD_SIZE; b++) begin : g_bit
      assign drv_pat[w*WORD_SIZE+b] = (word_q == WW'(w)) && mask_q[b];
      assign bl_pat[w*WORD_SIZE+b]  = drv_pat[w*WORD_SIZE+b] ? data_q[b]  : 1'b1;
      assign blb_pat[w*WORD_SIZE+b] = drv_pat[w*WORD_SIZE+b] ? ~data_q[b] : 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PRECHARGE;
          cnt_d   = PRE_LOAD;
        end
      end
      S_PRECHARGE: begin
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d   = DRIVE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    pre_d  = 1'b1;
    wl_d   = 1'b0;
    bl_d   = '1;
    blb_d  = '1;
    drv_d  = '0;
    done_d = (state_q == S_RECOVER) && (state_d == S_IDLE);
    unique case (state_d)
      S_DRIVE: begin
        pre_d = 1'b0;
        wl_d  = 1'b1;
        bl_d  = bl_pat;
        blb_d = blb_pat;
        drv_d = drv_pat;
      end
      S_RECOVER: begin
        pre_d = 1'b0;
        bl_d  = bl_q;
        blb_d = blb_q;
        drv_d = drv_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= 1'b1;
      wl_q    <= 1'b0;
      bl_q    <= '1;
      blb_q   <= '1;
      drv_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      wl_q    <= wl_d;
      bl_q    <= bl_d;
      blb_q   <= blb_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      word_q <= req_word;
      data_q <= req_data;
      mask_q <= req_mask;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign req_ready    = (state_q == S_IDLE);
  assign precharge_en = pre_q;
  assign wl_en        = wl_q;
  assign bl           = bl_q;
  assign blb          = blb_q;
  assign bl_drv_en    = drv_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bitline_write_sequencer.sv
// tb_bitline_write_sequencer: directed and random stimulus for two configurations
// of bitline_write_sequencer, with a queue of expected drive patterns.
`default_nettype none

module tb_bitline_write_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_pre, a_wl, a_busy, a_done;
  logic [3:0]  a_word, a_data, a_mask;
  logic [63:0] a_bl, a_blb, a_drv;

  logic        b_valid, b_ready, b_pre, b_wl, b_busy, b_done;
  logic [3:0]  b_word;
  logic [7:0]  b_data, b_mask;
  logic [95:0] b_bl, b_blb, b_drv;

  bitline_write_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_word(a_word), .req_data(a_data), .req_mask(a_mask),
    .precharge_en(a_pre), .wl_en(a_wl), .bl(a_bl), .blb(a_blb),
    .bl_drv_en(a_drv), .busy(a_busy), .done(a_done)
  );

  bitline_write_sequencer #(
    .WORD_SIZE(8), .NUM_WORDS(12), .PRE_CYCLES(2), .DRIVE_CYCLES(3), .REC_CYCLES(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_word(b_word), .req_data(b_data), .req_mask(b_mask),
    .precharge_en(b_pre), .wl_en(b_wl), .bl(b_bl), .blb(b_blb),
    .bl_drv_en(b_drv), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic [127:0] bl;
    logic [127:0] blb;
    logic [127:0] drv;
  } exp_t;

  typedef struct packed {
    logic pre, wl, busy, done, ready;
    logic [127:0] bl, blb, drv;
  } obs_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic exp_t model(input int ws, input int nw, input int word,
                                 input logic [7:0] data, input logic [7:0] mask);
    exp_t e;
    e.drv = '0;
    e.bl  = ones(ws * nw);
    e.blb = ones(ws * nw);
    if (word < nw) begin
      for (int b = 0; b < ws; b++) begin
        if (mask[b]) begin
          e.drv[word*ws+b] = 1'b1;
          e.bl[word*ws+b]  = data[b];
          e.blb[word*ws+b] = ~data[b];
        end
      end
    end
    return e;
  endfunction

  function automatic obs_t snap(input int sel);
    obs_t s;
    if (sel == 0) begin
      s.pre = a_pre; s.wl = a_wl; s.busy = a_busy; s.done = a_done; s.ready = a_ready;
      s.bl = 128'(a_bl); s.blb = 128'(a_blb); s.drv = 128'(a_drv);
    end else begin
      s.pre = b_pre; s.wl = b_wl; s.busy = b_busy; s.done = b_done; s.ready = b_ready;
      s.bl = 128'(b_bl); s.blb = 128'(b_blb); s.drv = 128'(b_drv);
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_phase(input int sel, input string ph, input logic pre, input logic wl,
                           input logic busy, input logic done, input logic [127:0] drv,
                           input logic [127:0] bl, input logic [127:0] blb);
    obs_t s = snap(sel);
    chk({ph, ".precharge_en"}, 128'(s.pre), 128'(pre));
    chk({ph, ".wl_en"}, 128'(s.wl), 128'(wl));
    chk({ph, ".busy"}, 128'(s.busy), 128'(busy));
    chk({ph, ".req_ready"}, 128'(s.ready), 128'(!busy));
    chk({ph, ".done"}, 128'(s.done), 128'(done));
    chk({ph, ".bl_drv_en"}, s.drv, drv);
    chk({ph, ".bl"}, s.bl, bl);
    chk({ph, ".blb"}, s.blb, blb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int sel, input logic valid, input int word,
                     input logic [7:0] data, input logic [7:0] mask, input bit push);
    if (sel == 0) begin
      a_valid = valid; a_word = 4'(word); a_data = data[3:0]; a_mask = mask[3:0];
      if (push) sbq.push_back(model(4, 16, word, data, mask));
    end else begin
      b_valid = valid; b_word = 4'(word); b_data = data; b_mask = mask;
      if (push) sbq.push_back(model(8, 12, word, data, mask));
    end
  endtask

  // Called in the first cycle after acceptance; returns in the done cycle.
  task automatic check_seq(input int sel, input int p, input int d, input int r, input int nc);
    exp_t e;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", sbq.size());
    end
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    for (int i = 0; i < p; i++) begin
      chk_phase(sel, "precharge", 1'b1, 1'b0, 1'b1, 1'b0, '0, ones(nc), ones(nc));
      step();
    end
    for (int i = 0; i < d; i++) begin
      chk_phase(sel, "drive", 1'b0, 1'b1, 1'b1, 1'b0, e.drv, e.bl, e.blb);
      step();
    end
    for (int i = 0; i < r; i++) begin
      chk_phase(sel, "recover", 1'b0, 1'b0, 1'b1, 1'b0, e.drv, e.bl, e.blb);
      step();
    end
    chk_phase(sel, "done", 1'b1, 1'b0, 1'b0, 1'b1, '0, ones(nc), ones(nc));
  endtask

  initial begin
    req(0, 1'b0, 0, 8'h0, 8'h0, 1'b0);
    req(1, 1'b0, 0, 8'h0, 8'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_phase(0, "reset_a", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(64), ones(64));
    chk_phase(1, "reset_b", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(96), ones(96));
    rst_n = 1'b1;
    step();

    repeat (3) begin
      chk_phase(0, "idle", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(64), ones(64));
      step();
    end

    // Full mask on word 5.
    req(0, 1'b1, 5, 8'hA, 8'hF, 1'b1);
    step();
    a_valid = 1'b0;
    check_seq(0, 1, 2, 1, 64);
    step();
    chk_phase(0, "after_done", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(64), ones(64));

    // Partial mask, then an all-zero mask.
    req(0, 1'b1, 0, 8'hF, 8'h5, 1'b1);
    step();
    a_valid = 1'b0;
    check_seq(0, 1, 2, 1, 64);
    step();
    req(0, 1'b1, 9, 8'h3, 8'h0, 1'b1);
    step();
    a_valid = 1'b0;
    check_seq(0, 1, 2, 1, 64);
    step();

    // Back-to-back: new request presented while busy, accepted in the done cycle.
    req(0, 1'b1, 3, 8'h6, 8'hF, 1'b1);
    step();
    req(0, 1'b1, 15, 8'h9, 8'hA, 1'b1);
    check_seq(0, 1, 2, 1, 64);
    step();
    a_valid = 1'b0;
    check_seq(0, 1, 2, 1, 64);
    step();

    // Reset asserted during the drive phase.
    req(0, 1'b1, 7, 8'h5, 8'hF, 1'b1);
    step();
    a_valid = 1'b0;
    step();
    chk("rst_pre.wl_en", 128'(a_wl), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk_phase(0, "rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(64), ones(64));
    void'(sbq.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      step();
      chk_phase(0, "post_rst", 1'b1, 1'b0, 1'b0, 1'b0, '0, ones(64), ones(64));
    end

    // Wide configuration: last valid word, then an out-of-range word.
    req(1, 1'b1, 11, 8'hC3, 8'hFF, 1'b1);
    step();
    b_valid = 1'b0;
    check_seq(1, 2, 3, 2, 96);
    step();
    req(1, 1'b1, 13, 8'hAA, 8'hFF, 1'b1);
    step();
    b_valid = 1'b0;
    check_seq(1, 2, 3, 2, 96);
    step();

    // Random traffic with interlock checks every cycle.
    for (int i = 0; i < 300; i++) begin
      req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          8'($urandom), 8'($urandom), 1'b0);
      step();
      chk("il_wl_and_pre", 128'(b_wl & b_pre), 128'(1'b0));
      chk("il_drv_and_pre", 128'((|b_drv) & b_pre), 128'(1'b0));
      chk("il_bl_blb_low", 128'(|(~b_bl & ~b_blb)), 128'(1'b0));
      chk("il_ready_busy", 128'(b_ready), 128'(!b_busy));
    end
    b_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
